vec_search_ctrl: RTL and testbench
==================================

// Module: vec_search_ctrl
// PURPOSE
//  Sequencer that drives a synchronous-read lookup table (the VecSearch-style constant vector) to find a key.
//  - Accepts a key over a valid/ready start handshake.
//  - Walks table addresses 0..DEPTH-1 and compares each returned word with the key.
//  - Returns first-match index, or miss, over a valid/ready result handshake.
//  - Sits between a requester (CPU/test driver) and the table; owns the table's read port.
// PARAMETERS
//  DEPTH   8                 table entries, >=2
//  DATA_W  4                 table word / key width
//  IDX_W   $clog2(DEPTH)     address/index width (derived localparam)
// PORTS
//  clock        in   1       single clock, rising edge
//  reset        in   1       asynchronous, active-low (0 = reset)
//  start_valid  in   1       search request
//  start_ready  out  1       high only in IDLE
//  key          in   DATA_W  search key, sampled on start handshake
//  abort        in   1       synchronous cancel of running scan
//  rd_en        out  1       table read enable
//  rd_addr      out  IDX_W   table read address
//  rd_data      in   DATA_W  table data, valid 1 cycle after rd_en
//  res_valid    out  1       result available
//  res_ready    in   1       result consumed
//  res_found    out  1       1 = match, 0 = miss
//  res_index    out  IDX_W   first matching address (0 on miss)
//  busy         out  1       high in SCAN or RESP
// BEHAVIOUR
//  - Reset (reset=0, async): state=IDLE; key_q=0; idx=0; all outputs 0 except start_ready=1.
//  - FSM IDLE->SCAN on start_valid&&start_ready (edge E): latch key_q, idx=0, cmp_vld=0.
//  - SCAN:
//    - rd_en=1, rd_addr=idx while idx<=DEPTH-1; idx increments each cycle, saturating (no wrap).
//    - cmp_vld/cmp_idx is a registered copy of the previous cycle's rd_en/rd_addr.
//    - When cmp_vld and rd_data==key_q: ->RESP, found=1, index=cmp_idx.
//    - When cmp_vld and cmp_idx==DEPTH-1 with no match: ->RESP, found=0, index=0.
//  - Latency: first match at i gives res_valid high after edge E+i+2; miss gives res_valid after edge E+DEPTH+1.
//  - Over-read: address i+1 may be read after a match at i. Reads have no side effects; this is legal.
//  - RESP: res_valid=1; outputs held stable until res_valid&&res_ready, then ->IDLE.
//    - start_ready=0 during RESP; no new start until the result is consumed.
//  - abort:
//    - In SCAN: ->IDLE next edge; no result produced; rd_en=0 next cycle.
//    - In IDLE/RESP: ignored.
//    - abort and match in the same cycle: abort wins.
//  - Simultaneous res_ready and start_valid in RESP: result consumed; start not accepted (start_ready=0).
//  - Duplicate keys in table: lowest address reported.
//  - Async reset mid-scan or mid-RESP: immediate return to reset values; pending result lost.
// CONFIGURATION
//  - VEC_SEARCH_CTRL_PERF_EN defined:
//    - Adds output perf_cycles[15:0]: counts cycles with busy=1.
//    - Saturates at 16'hFFFF; cleared by reset only.
//  - Not defined: port absent; no counter logic.
// STRUCTURE
//  - Package vec_search_pkg:
//    - state_e enum {IDLE, SCAN, RESP}.
//    - Shared DATA_W/DEPTH defaults.
//    - Function clog2 helper.
//  - Sub-module vs_idx_counter:
//    - Load-to-zero, increment, saturate-at-DEPTH-1 address counter.
//    - Flags last address.
//  - FSM and compare pipeline stay in the top module.
// TESTING (table = {2,4,6,8,1,3,5,7}, DEPTH=8, DATA_W=4)
//  - key=6, res_ready=1 -> res_valid after edge E+4, found=1, index=2, then start_ready=1.
//  - key=9 -> res_valid after edge E+9, found=0, index=0; rd_addr never exceeds 7.
//  - key=2 -> found at index 0 after edge E+2.
//  - key=7 -> found at index 7.
//  - Duplicate table {5,5,...}, key=5 -> index=0.
//  - key=7, res_ready=0 for 5 cycles -> res_* stable, start_valid ignored.
//    Then res_ready=1 -> IDLE next cycle.
//  - Abort and reset cases:
//    - abort asserted in scan cycle 3 (key=7) -> no res_valid, IDLE after 1 edge.
//    - abort coincident with match cycle -> no result.
//    - reset=0 pulse mid-scan -> all outputs at reset values immediately.
//  - PERF_EN: key=9 search -> perf_cycles increments by 10 (9 SCAN + 1 RESP with res_ready=1).

Source files
------------

// File: rtl/vec_search_pkg.sv
// Shared types and defaults for the vector-search sequencer.
package vec_search_pkg;

  localparam int unsigned DEF_DEPTH  = 8;
  localparam int unsigned DEF_DATA_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    v = (value > 1) ? value - 1 : 0;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/vs_idx_counter.sv
// Table address counter: clears to zero, increments, and saturates at the last entry.
module vs_idx_counter #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [IDX_W-1:0] idx,
  output logic             last
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  assign last = (idx == LAST_IDX);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx <= '0;
    end else if (clear) begin
      idx <= '0;
    end else if (inc && !last) begin
      idx <= idx + 1'b1;
    end
  end

endmodule

// File: rtl/vec_search_ctrl.sv
// Sequencer that scans a synchronous-read table for a key and returns the first match.
// Optional busy-cycle counter output perf_cycles when VEC_SEARCH_CTRL_PERF_EN is defined.
module vec_search_ctrl
  import vec_search_pkg::*;
#(
  parameter  int unsigned DEPTH  = DEF_DEPTH,
  parameter  int unsigned DATA_W = DEF_DATA_W,
  localparam int unsigned IDX_W  = clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [DATA_W-1:0] key,
  input  logic              abort,
  output logic              rd_en,
  output logic [IDX_W-1:0]  rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_found,
  output logic [IDX_W-1:0]  res_index,
  output logic              busy
`ifdef VEC_SEARCH_CTRL_PERF_EN
  ,
  output logic [15:0]       perf_cycles
`endif
);

  state_e              state_q;
  state_e              state_d;
  logic [DATA_W-1:0]   key_q;
  logic                cmp_vld;
  logic [IDX_W-1:0]    cmp_idx;
  logic                cmp_last;
  logic                found_q;
  logic [IDX_W-1:0]    index_q;
  logic                cnt_clear;
  logic                cnt_inc;
  logic [IDX_W-1:0]    idx;
  logic                idx_last;
  logic                load_hit;
  logic                load_miss;

  vs_idx_counter #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_idx (
    .clock (clock),
    .reset (reset),
    .clear (cnt_clear),
    .inc   (cnt_inc),
    .idx   (idx),
    .last  (idx_last)
  );

  assign start_ready = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign rd_en       = (state_q == SCAN);
  assign rd_addr     = rd_en ? idx : '0;
  assign res_valid   = (state_q == RESP);
  assign res_found   = res_valid & found_q;
  assign res_index   = res_valid ? index_q : '0;

  // Abort is tested before the compare so a coincident match is dropped.
  always_comb begin
    state_d   = state_q;
    cnt_clear = 1'b0;
    cnt_inc   = 1'b0;
    load_hit  = 1'b0;
    load_miss = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_valid) begin
          state_d   = SCAN;
          cnt_clear = 1'b1;
        end
      end
      SCAN: begin
        cnt_inc = 1'b1;
        if (abort) begin
          state_d = IDLE;
        end else if (cmp_vld && (rd_data == key_q)) begin
          state_d  = RESP;
          load_hit = 1'b1;
        end else if (cmp_vld && cmp_last) begin
          state_d   = RESP;
          load_miss = 1'b1;
        end
      end
      RESP: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // cmp_* tracks the read issued last cycle, aligned with rd_data.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      key_q    <= '0;
      cmp_vld  <= 1'b0;
      cmp_idx  <= '0;
      cmp_last <= 1'b0;
      found_q  <= 1'b0;
      index_q  <= '0;
    end else begin
      state_q  <= state_d;
      cmp_vld  <= rd_en;
      cmp_idx  <= rd_addr;
      cmp_last <= rd_en && idx_last;
      if (cnt_clear) begin
        key_q <= key;
      end
      if (load_hit) begin
        found_q <= 1'b1;
        index_q <= cmp_idx;
      end else if (load_miss) begin
        found_q <= 1'b0;
        index_q <= '0;
      end
    end
  end

`ifdef VEC_SEARCH_CTRL_PERF_EN
  logic [15:0] perf_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_q <= '0;
    end else if (busy && (perf_q != '1)) begin
      perf_q <= perf_q + 16'd1;
    end
  end

  assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_vec_search_ctrl.sv
// Self-checking bench for vec_search_ctrl: directed latency cases plus randomized traffic vs a cycle model.
module tb_vec_search_ctrl;

  localparam int unsigned DEPTH  = 8;
  localparam int unsigned DATA_W = 4;
  localparam int unsigned IDX_W  = 3;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              start_valid = 1'b0;
  logic              abort = 1'b0;
  logic              res_ready = 1'b0;
  logic [DATA_W-1:0] key = '0;
  logic [DATA_W-1:0] rd_data = '0;
  logic              start_ready;
  logic              rd_en;
  logic              res_valid;
  logic              res_found;
  logic              busy;
  logic [IDX_W-1:0]  rd_addr;
  logic [IDX_W-1:0]  res_index;
`ifdef VEC_SEARCH_CTRL_PERF_EN
  logic [15:0]       perf_cycles;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int dperf = 0;
  logic [DATA_W-1:0] mem [DEPTH];

  vec_search_ctrl #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .key         (key),
    .abort       (abort),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_found   (res_found),
    .res_index   (res_index),
    .busy        (busy)
`ifdef VEC_SEARCH_CTRL_PERF_EN
    ,
    .perf_cycles (perf_cycles)
`endif
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Synchronous-read table
  always @(posedge clock) if (rd_en) rd_data <= mem[rd_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: result and its due time are computed at acceptance from the table contents.
  int   m_mode = 0;  // 0 idle, 1 searching, 2 result pending
  int   m_k = 0;
  int   m_due = 0;
  int   m_h = 0;
  int   m_index = 0;
  logic m_found = 1'b0;
  int   m_perf = 0;

  function automatic int first_hit(input logic [DATA_W-1:0] k);
    for (int i = 0; i < DEPTH; i++) if (mem[i] == k) return i;
    return -1;
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_mode = 0;
      m_k    = 0;
      m_perf = 0;
    end else begin
      if (m_mode != 0 && m_perf < 65535) m_perf++;
      case (m_mode)
        0: if (start_valid) begin
          m_h     = first_hit(key);
          m_mode  = 1;
          m_k     = 0;
          m_found = (m_h >= 0);
          m_index = (m_h >= 0) ? m_h : 0;
          m_due   = (m_h >= 0) ? m_h + 2 : DEPTH + 1;
        end
        1: if (abort) m_mode = 0;
           else begin
             m_k++;
             if (m_k == m_due) m_mode = 2;
           end
        2: if (res_ready) m_mode = 0;
        default: m_mode = 0;
      endcase
    end
  end

  always @(negedge clock) begin
    check("start_ready", start_ready, m_mode == 0);
    check("busy", busy, m_mode != 0);
    check("rd_en", rd_en, m_mode == 1);
    check("rd_addr", rd_addr, (m_mode == 1) ? ((m_k < DEPTH - 1) ? m_k : DEPTH - 1) : 0);
    check("res_valid", res_valid, m_mode == 2);
    check("res_found", res_found, (m_mode == 2) && m_found);
    check("res_index", res_index, (m_mode == 2) ? m_index : 0);
`ifdef VEC_SEARCH_CTRL_PERF_EN
    check("perf_cycles", perf_cycles, m_perf);
`endif
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_start_ready"}, start_ready, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_rd_en"}, rd_en, 0);
    check({tag, "_rd_addr"}, rd_addr, 0);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_res_found"}, res_found, 0);
    check({tag, "_res_index"}, res_index, 0);
  endtask

  task automatic search(input logic [DATA_W-1:0] k, input int hold,
                        output int lat, output logic f, output int ix);
    int e0;
    int t;
    int p0;
    p0 = 0;
    @(posedge clock); #1;
    start_valid = 1'b1;
    key         = k;
    res_ready   = (hold == 0);
    @(posedge clock); #1;
    e0 = cyc;
    start_valid = 1'b0;
`ifdef VEC_SEARCH_CTRL_PERF_EN
    p0 = perf_cycles;
`endif
    check("accepted", busy, 1);
    t = 0;
    while (!res_valid && t < 40) begin
      @(posedge clock); #1;
      t++;
    end
    check("result_timeout", t < 40, 1);
    lat = cyc - e0;
    f   = res_found;
    ix  = res_index;
    if (hold > 0) begin
      start_valid = 1'b1;
      repeat (hold) begin
        @(posedge clock); #1;
        check("hold_valid", res_valid, 1);
        check("hold_found", res_found, f);
        check("hold_index", res_index, ix);
        check("hold_start_ready", start_ready, 0);
      end
      res_ready = 1'b1;
    end
    @(posedge clock); #1;
    start_valid = 1'b0;
    res_ready   = 1'b0;
    check("idle_after_consume", start_ready, 1);
    check("no_restart", busy, 0);
`ifdef VEC_SEARCH_CTRL_PERF_EN
    dperf = int'(perf_cycles) - p0;
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int   lat;
    int   ix;
    int   t;
    logic f;
    mem = '{4'd2, 4'd4, 4'd6, 4'd8, 4'd1, 4'd3, 4'd5, 4'd7};
    #1 reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_reset_outputs("por");
`ifdef VEC_SEARCH_CTRL_PERF_EN
    check("por_perf", perf_cycles, 0);
`endif
    reset = 1'b1;

    search(4'd6, 0, lat, f, ix);
    check("k6_latency", lat, 4);
    check("k6_found", f, 1);
    check("k6_index", ix, 2);

    search(4'd9, 0, lat, f, ix);
    check("k9_latency", lat, 9);
    check("k9_found", f, 0);
    check("k9_index", ix, 0);
`ifdef VEC_SEARCH_CTRL_PERF_EN
    check("k9_perf_delta", dperf, 10);
`endif

    search(4'd2, 0, lat, f, ix);
    check("k2_latency", lat, 2);
    check("k2_found", f, 1);
    check("k2_index", ix, 0);

    search(4'd7, 0, lat, f, ix);
    check("k7_latency", lat, 9);
    check("k7_found", f, 1);
    check("k7_index", ix, 7);

    search(4'd7, 5, lat, f, ix);
    check("k7_hold_latency", lat, 9);
    check("k7_hold_index", ix, 7);

    mem = '{4'd5, 4'd5, 4'd1, 4'd5, 4'd3, 4'd5, 4'd0, 4'd5};
    search(4'd5, 0, lat, f, ix);
    check("dup_latency", lat, 2);
    check("dup_found", f, 1);
    check("dup_index", ix, 0);
    mem = '{4'd2, 4'd4, 4'd6, 4'd8, 4'd1, 4'd3, 4'd5, 4'd7};

    // Abort in the third scan cycle
    @(posedge clock); #1;
    start_valid = 1'b1; key = 4'd7;
    @(posedge clock); #1;
    start_valid = 1'b0;
    repeat (2) begin @(posedge clock); #1; end
    abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    check("abort3_busy", busy, 0);
    check("abort3_start_ready", start_ready, 1);
    repeat (12) begin
      @(posedge clock); #1;
      check("abort3_no_result", res_valid, 0);
    end

    // Abort in the same cycle as the match for key 6
    @(posedge clock); #1;
    start_valid = 1'b1; key = 4'd6;
    @(posedge clock); #1;
    start_valid = 1'b0;
    repeat (3) begin @(posedge clock); #1; end
    abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    check("abort_match_valid", res_valid, 0);
    check("abort_match_busy", busy, 0);

    // Async reset mid-scan
    @(posedge clock); #1;
    start_valid = 1'b1; key = 4'd9;
    @(posedge clock); #1;
    start_valid = 1'b0;
    repeat (2) begin @(posedge clock); #1; end
    #2 reset = 1'b0;
    #1 check_reset_outputs("rst_scan");
`ifdef VEC_SEARCH_CTRL_PERF_EN
    check("rst_scan_perf", perf_cycles, 0);
`endif
    @(posedge clock); #1;
    reset = 1'b1;

    // Async reset while a result is pending
    @(posedge clock); #1;
    start_valid = 1'b1; key = 4'd4; res_ready = 1'b0;
    @(posedge clock); #1;
    start_valid = 1'b0;
    t = 0;
    while (!res_valid && t < 20) begin @(posedge clock); #1; t++; end
    check("rst_resp_reached", res_valid, 1);
    #2 reset = 1'b0;
    #1 check_reset_outputs("rst_resp");
    @(posedge clock); #1;
    reset = 1'b1;

    // Randomized traffic against the model
    for (int blk = 0; blk < 6; blk++) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = 4'($urandom_range(0, 9));
      for (int c = 0; c < 300; c++) begin
        @(posedge clock); #1;
        start_valid = ($urandom_range(0, 3) != 0);
        key         = 4'($urandom_range(0, 11));
        abort       = ($urandom_range(0, 19) == 0);
        res_ready   = ($urandom_range(0, 2) != 0);
      end
      start_valid = 1'b0;
      abort       = 1'b0;
      res_ready   = 1'b1;
      t = 0;
      @(posedge clock); #1;
      while (!start_ready && t < 30) begin @(posedge clock); #1; t++; end
      check("drain_idle", start_ready, 1);
      res_ready = 1'b0;
    end

    repeat (2) @(posedge clock);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
